// File: rtl/rr_grant_sequencer_4_pkg.sv
// Shared types and constants for the four-way round-robin grant sequencer.
// The FSM encoding is fixed so the state can be decoded by other logic if needed.
package rr_grant_sequencer_4_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: the first set request at or after ptr (mod 4).
// Rotate so ptr lands on bit 0, take the lowest set bit, then rotate the index back.
module rr_pick_4
   import rr_grant_sequencer_4_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [N_REQ-1:0] w_rot;
   logic [IDX_W-1:0] w_off;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
         assign w_rot[gi] = i_req[IDX_W'(gi) + i_ptr];
      end
   endgenerate

   always_comb begin
      w_off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = IDX_W'(k);
         end
      end
   end

   assign o_idx = i_ptr + w_off;
   assign o_any = |i_req;

endmodule

// File: rtl/rr_grant_sequencer_4.sv
// Round-robin arbiter producing an index plus enable for a 2-to-4 decoder, with a
// one-cycle dead gap between grants and a bounded tenure when others are waiting.
module rr_grant_sequencer_4
   import rr_grant_sequencer_4_pkg::*;
#(
   parameter int MAX_HOLD = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [IDX_W-1:0] sel,
   output logic             sel_valid,
   output logic             forced,
   output logic             busy
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   state_t            r_state;
   state_t            w_state_next;
   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  w_ptr_next;
   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] w_hold_next;
   logic [IDX_W-1:0]  r_sel;
   logic [IDX_W-1:0]  w_sel_next;
   logic              r_sel_valid;
   logic              r_forced;
   logic              w_forced_next;
   logic              r_busy;
   logic [IDX_W-1:0]  w_pick;
   logic              w_any;
   logic [N_REQ-1:0]  w_others;

   rr_pick_4 u_pick (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_idx (w_pick),
      .o_any (w_any)
   );

   assign w_others = req & ~onehot(r_sel);

   always_comb begin
      w_state_next  = r_state;
      w_ptr_next    = r_ptr;
      w_hold_next   = r_hold;
      w_sel_next    = r_sel;
      w_forced_next = 1'b0;
      case (r_state)
         ST_IDLE, ST_GAP: begin
            if (w_any) begin
               w_state_next = ST_GRANT;
               w_sel_next   = w_pick;
               w_hold_next  = HOLD_W'(1);
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_GRANT: begin
            // A release takes priority over a timeout that lands in the same cycle.
            if (!req[r_sel]) begin
               w_state_next = ST_GAP;
               w_ptr_next   = r_sel + 2'd1;
            end else if ((r_hold >= HOLD_MAX) && (|w_others)) begin
               w_state_next  = ST_GAP;
               w_ptr_next    = r_sel + 2'd1;
               w_forced_next = 1'b1;
            end else if (r_hold < HOLD_MAX) begin
               w_hold_next = r_hold + HOLD_W'(1);
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_hold      <= '0;
         r_sel       <= '0;
         r_sel_valid <= 1'b0;
         r_forced    <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_ptr       <= w_ptr_next;
         r_hold      <= w_hold_next;
         r_sel       <= w_sel_next;
         r_sel_valid <= (w_state_next == ST_GRANT);
         r_forced    <= w_forced_next;
         r_busy      <= (w_state_next != ST_IDLE);
      end
   end

   assign sel       = r_sel;
   assign sel_valid = r_sel_valid;
   assign forced    = r_forced;
   assign busy      = r_busy;

endmodule
